// File: rtl/toggle_pkg.sv
// Shared constants for the toggle encoder/decoder pair.
// pend_max() gives the largest pending-event count a PEND_W counter can hold.
package toggle_pkg;

    localparam int unsigned CNT_W_DEFAULT  = 8;
    localparam int unsigned PEND_W_DEFAULT = 4;

    function automatic int unsigned pend_max(input int unsigned pend_w);
        return (32'd1 << pend_w) - 32'd1;
    endfunction

endpackage

// File: rtl/toggle_sync2.sv
// Two-flop synchronizer for a single line from an unrelated clock domain.
// Both stages reset to 0 synchronously.
module toggle_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/toggle_decoder.sv
// Turns each level transition on t_in into a queued event token (valid/ready).
// Define TOGGLE_DECODER_SYNC_EN to pass t_in through a two-flop synchronizer first.
module toggle_decoder
    import toggle_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEFAULT,
    parameter int unsigned PEND_W = PEND_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              t_in,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [PEND_W-1:0] pend,
    output logic [CNT_W-1:0]  ev_count,
    output logic              ovf,
    output logic              q,
    output logic              qn
);

    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(pend_max(PEND_W));

    logic t_s;

`ifdef TOGGLE_DECODER_SYNC_EN
    toggle_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (t_in),
        .q   (t_s)
    );
`else
    assign t_s = t_in;
`endif

    logic              t_d_q, t_d_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]  ev_count_q, ev_count_d;
    logic              ovf_q, ovf_d;
    logic              detect, take;

    always_comb begin
        t_d_d      = t_s;
        pend_d     = pend_q;
        ev_count_d = ev_count_q;
        ovf_d      = ovf_q;

        detect = en && (t_s != t_d_q);
        take   = (pend_q != '0) && ev_ready;

        if (detect) begin
            ev_count_d = ev_count_q + 1'b1;
        end

        // A simultaneous detect and take leaves pend untouched, even when full.
        if (detect && !take) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (take && !detect) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_d_q      <= 1'b0;
            pend_q     <= '0;
            ev_count_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            t_d_q      <= t_d_d;
            pend_q     <= pend_d;
            ev_count_q <= ev_count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ev_valid = (pend_q != '0);
    assign pend     = pend_q;
    assign ev_count = ev_count_q;
    assign ovf      = ovf_q;
    assign q        = t_d_q;
    assign qn       = ~t_d_q;

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder (CNT_W=8, PEND_W=4), hand-computed expectations.
// Works with or without TOGGLE_DECODER_SYNC_EN; LAT absorbs the synchronizer delay.
module tb_toggle_decoder;

`ifdef TOGGLE_DECODER_SYNC_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       t_in;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] pend;
    logic [7:0] ev_count;
    logic       ovf;
    logic       q;
    logic       qn;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    toggle_decoder #(
        .CNT_W  (8),
        .PEND_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .t_in     (t_in),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .pend     (pend),
        .ev_count (ev_count),
        .ovf      (ovf),
        .q        (q),
        .qn       (qn)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic toggles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            t_in = ~t_in;
            tick(1);
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        t_in     = 1'b1;
        ev_ready = 1'b0;
        @(negedge clk);

        // Reset held with t_in=1, released with en=0: level absorbed, no event
        tick(2);
        check_eq("rst_q",     32'(q),        32'd0);
        check_eq("rst_qn",    32'(qn),       32'd1);
        check_eq("rst_valid", 32'(ev_valid), 32'd0);
        rst = 1'b0;
        tick(1 + LAT);
        check_eq("rel_q",     32'(q),        32'd1);
        check_eq("rel_qn",    32'(qn),       32'd0);
        check_eq("rel_pend",  32'(pend),     32'd0);
        check_eq("rel_count", 32'(ev_count),32'd0);
        check_eq("rel_ovf",   32'(ovf),      32'd0);

        // Basic: three toggles queued, then drained
        en = 1'b1;
        toggles(3);
        tick(LAT);
        check_eq("basic_pend",  32'(pend),     32'd3);
        check_eq("basic_count", 32'(ev_count), 32'd3);
        check_eq("basic_valid", 32'(ev_valid), 32'd1);
        ev_ready = 1'b1;
        tick(1);
        check_eq("take1_pend", 32'(pend), 32'd2);
        tick(2);
        ev_ready = 1'b0;
        check_eq("drain_pend",  32'(pend),     32'd0);
        check_eq("drain_valid", 32'(ev_valid), 32'd0);
        tick(1);
        check_eq("idle_ready_pend", 32'(pend), 32'd0);

        // Overflow: fill to 15 exactly, then two more are dropped
        toggles(15);
        tick(LAT);
        check_eq("full_pend",  32'(pend),     32'd15);
        check_eq("full_ovf",   32'(ovf),      32'd0);
        check_eq("full_count", 32'(ev_count), 32'd18);
        toggles(2);
        tick(LAT);
        check_eq("ovf_pend",  32'(pend),     32'd15);
        check_eq("ovf_count", 32'(ev_count), 32'd20);
        check_eq("ovf_set",   32'(ovf),      32'd1);
        ev_ready = 1'b1;
        tick(15);
        ev_ready = 1'b0;
        check_eq("ovf_drain_pend", 32'(pend),     32'd0);
        check_eq("ovf_sticky",     32'(ovf),      32'd1);
        check_eq("ovf_drain_valid",32'(ev_valid), 32'd0);

        // Reset clears ovf; en=0 while the line level (1) is absorbed
        en  = 1'b0;
        rst = 1'b1;
        tick(1);
        check_eq("rst2_ovf",   32'(ovf),      32'd0);
        check_eq("rst2_count", 32'(ev_count), 32'd0);
        rst = 1'b0;
        tick(1 + LAT);
        check_eq("rst2_pend", 32'(pend), 32'd0);

        // Simultaneous detect and take at full queue
        en = 1'b1;
        toggles(15);
        tick(LAT);
        check_eq("sim_pre_pend", 32'(pend), 32'd15);
        t_in = ~t_in;
        tick(LAT);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        check_eq("sim_pend",  32'(pend),     32'd15);
        check_eq("sim_ovf",   32'(ovf),      32'd0);
        check_eq("sim_count", 32'(ev_count), 32'd16);

        // Enable gating: toggles with en=0, then re-enable on a steady line
        en = 1'b0;
        toggles(5);
        tick(1 + LAT);
        en = 1'b1;
        tick(3 + LAT);
        check_eq("gate_count", 32'(ev_count), 32'd16);
        check_eq("gate_pend",  32'(pend),     32'd15);
        ev_ready = 1'b1;
        tick(15);
        check_eq("gate_drain", 32'(pend), 32'd0);

        // Sustained toggle+take; 240 more events wraps the 8-bit count to 0
        toggles(240);
        tick(LAT);
        check_eq("wrap_count", 32'(ev_count), 32'd0);
        check_eq("steady_pend", 32'(pend),   32'd1);
        tick(1);
        check_eq("steady_drain", 32'(pend),  32'd0);
        ev_ready = 1'b0;

        // Mid-run reset discards pending events
        toggles(2);
        tick(LAT);
        check_eq("mid_pre_pend", 32'(pend), 32'd2);
        rst  = 1'b1;
        t_in = 1'b1;
        tick(1);
        check_eq("mid_pend",  32'(pend),     32'd0);
        check_eq("mid_count", 32'(ev_count), 32'd0);
        check_eq("mid_q",     32'(q),        32'd0);
        check_eq("mid_valid", 32'(ev_valid), 32'd0);

        // t_in=1 with en=1 after reset gives exactly one event
        rst = 1'b0;
        tick(1 + LAT);
        check_eq("first_count", 32'(ev_count), 32'd1);
        check_eq("first_pend",  32'(pend),     32'd1);
        check_eq("first_valid", 32'(ev_valid), 32'd1);
        check_eq("first_q",     32'(q),        32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
